// File: rtl/debouncer_bank_if.sv
// Signal bundle between the raw board pins / delay control and the debounced
// level and edge-event outputs of debouncer_bank.
interface debouncer_bank_if #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 20
);
  logic [CHANNELS-1:0] in_raw;
  logic [CNT_W-1:0]    delay;
  logic                enable;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press;
  // 'release' is a reserved word in SystemVerilog, hence the longer name.
  logic [CHANNELS-1:0] release_pulse;

  modport master (
    output in_raw, delay, enable,
    input  level, press, release_pulse
  );

  modport slave (
    input  in_raw, delay, enable,
    output level, press, release_pulse
  );
endinterface

// File: rtl/debouncer_bank.sv
// N-channel key/switch debouncer: 2-FF synchroniser, per-channel stability
// counter against a shared programmable window, held level and 1-cycle edge pulses.
module debouncer_bank #(
  parameter int CHANNELS   = 8,
  parameter int CNT_W      = 20,
  parameter int ACTIVE_LOW = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  debouncer_bank_if.slave bus
);

  localparam logic [CHANNELS-1:0] IDLE_PINS =
    (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  function automatic logic [CNT_W-1:0] thr_of(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  // One extra bit so count+1 cannot wrap before the compare.
  function automatic logic reached(input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] thr);
    return ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, thr};
  endfunction

  logic [CHANNELS-1:0] sync_p0;
  logic [CHANNELS-1:0] sync_p1;
  logic [CHANNELS-1:0] x_p1;
  logic [CNT_W-1:0]    thr;

  logic [CNT_W-1:0]    cnt_p2  [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] level_p2;
  logic [CHANNELS-1:0] press_p2;
  logic [CHANNELS-1:0] rls_p2;
  logic [CHANNELS-1:0] level_nxt;
  logic [CHANNELS-1:0] press_nxt;
  logic [CHANNELS-1:0] rls_nxt;

  // Stage p0/p1: metastability synchroniser, free-running even when disabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= IDLE_PINS;
      sync_p1 <= IDLE_PINS;
    end else begin
      sync_p0 <= bus.in_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign x_p1 = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;
  assign thr  = thr_of(bus.delay);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i]   = cnt_p2[i];
      level_nxt[i] = level_p2[i];
      press_nxt[i] = 1'b0;
      rls_nxt[i]   = 1'b0;
      if (bus.enable) begin
        if (x_p1[i] == level_p2[i]) begin
          cnt_nxt[i] = '0;
        end else if (reached(cnt_p2[i], thr)) begin
          cnt_nxt[i]   = '0;
          level_nxt[i] = x_p1[i];
          press_nxt[i] = x_p1[i];
          rls_nxt[i]   = ~x_p1[i];
        end else begin
          cnt_nxt[i] = cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stage p2: per-channel stability counter, held level and edge pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_p2[i] <= '0;
      end
      level_p2 <= '0;
      press_p2 <= '0;
      rls_p2   <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_p2[i] <= cnt_nxt[i];
      end
      level_p2 <= level_nxt;
      press_p2 <= press_nxt;
      rls_p2   <= rls_nxt;
    end
  end

  assign bus.level         = level_p2;
  assign bus.press         = press_p2;
  assign bus.release_pulse = rls_p2;

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed, table-driven bench for debouncer_bank (8 channels, active-low pins).
module tb_debouncer_bank;

  localparam int CH = 8;
  localparam int CW = 20;

  logic clock;
  logic reset_n;

  debouncer_bank_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  debouncer_bank #(.CHANNELS(CH), .CNT_W(CW), .ACTIVE_LOW(1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [CH-1:0] raw;
    logic [CW-1:0] dly;
    logic          en;
    logic [CH-1:0] lvl;
    logic [CH-1:0] prs;
    logic [CH-1:0] rls;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input int n, input logic [CH-1:0] raw,
                              input int dly, input logic en,
                              input logic [CH-1:0] lvl,
                              input logic [CH-1:0] prs,
                              input logic [CH-1:0] rls);
    vec_t v;
    v.raw = raw; v.dly = CW'(dly); v.en = en;
    v.lvl = lvl; v.prs = prs; v.rls = rls;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [CH-1:0] got,
                       input logic [CH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [CH-1:0] lvl,
                            input logic [CH-1:0] prs, input logic [CH-1:0] rls);
    check({tag, ".level"},   bus.level,         lvl);
    check({tag, ".press"},   bus.press,         prs);
    check({tag, ".release"}, bus.release_pulse, rls);
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input string tag, input logic [CH-1:0] raw, input int dly,
                      input logic en, input logic [CH-1:0] lvl,
                      input logic [CH-1:0] prs, input logic [CH-1:0] rls);
    bus.in_raw = raw;
    bus.delay  = CW'(dly);
    bus.enable = en;
    @(posedge clock);
    #1;
    check_outs(tag, lvl, prs, rls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1) idle after reset
    add(20, 8'hFF, 4, 1'b1, 8'h00, 8'h00, 8'h00);
    // 2) ch0 pressed, delay 4: level at capture edge + 5
    add(5,  8'hFE, 4, 1'b1, 8'h00, 8'h00, 8'h00);
    add(1,  8'hFE, 4, 1'b1, 8'h01, 8'h01, 8'h00);
    add(1,  8'hFE, 4, 1'b1, 8'h01, 8'h00, 8'h00);
    // 3) ch1 bounces low,low,high; then settles low
    for (int k = 0; k < 3; k++) begin
      add(2, 8'hFC, 4, 1'b1, 8'h01, 8'h00, 8'h00);
      add(1, 8'hFE, 4, 1'b1, 8'h01, 8'h00, 8'h00);
    end
    add(5,  8'hFC, 4, 1'b1, 8'h01, 8'h00, 8'h00);
    add(1,  8'hFC, 4, 1'b1, 8'h03, 8'h02, 8'h00);
    add(1,  8'hFC, 4, 1'b1, 8'h03, 8'h00, 8'h00);
    // 4) delay 1: press ch7, then release ch0 and ch7 together
    add(2,  8'h7C, 1, 1'b1, 8'h03, 8'h00, 8'h00);
    add(1,  8'h7C, 1, 1'b1, 8'h83, 8'h80, 8'h00);
    add(1,  8'h7C, 1, 1'b1, 8'h83, 8'h00, 8'h00);
    add(2,  8'hFD, 1, 1'b1, 8'h83, 8'h00, 8'h00);
    add(1,  8'hFD, 1, 1'b1, 8'h02, 8'h00, 8'h81);
    add(1,  8'hFD, 1, 1'b1, 8'h02, 8'h00, 8'h00);
    // 5) release ch1 with delay 10, lower to 3 once count reaches 5
    add(7,  8'hFF, 10, 1'b1, 8'h02, 8'h00, 8'h00);
    add(1,  8'hFF, 3,  1'b1, 8'h00, 8'h00, 8'h02);
    add(1,  8'hFF, 3,  1'b1, 8'h00, 8'h00, 8'h00);
    // 5b) delay 0 acts as delay 1 on ch2 press and release
    add(2,  8'hFB, 0, 1'b1, 8'h00, 8'h00, 8'h00);
    add(1,  8'hFB, 0, 1'b1, 8'h04, 8'h04, 8'h00);
    add(1,  8'hFB, 0, 1'b1, 8'h04, 8'h00, 8'h00);
    add(2,  8'hFF, 0, 1'b1, 8'h04, 8'h00, 8'h00);
    add(1,  8'hFF, 0, 1'b1, 8'h00, 8'h00, 8'h04);
    add(1,  8'hFF, 0, 1'b1, 8'h00, 8'h00, 8'h00);
    // 6a) ch3 press frozen at count 2 for 6 cycles, resumes from held count
    add(4,  8'hF7, 4, 1'b1, 8'h00, 8'h00, 8'h00);
    add(6,  8'hF7, 4, 1'b0, 8'h00, 8'h00, 8'h00);
    add(1,  8'hF7, 4, 1'b1, 8'h00, 8'h00, 8'h00);
    add(1,  8'hF7, 4, 1'b1, 8'h08, 8'h08, 8'h00);
    add(1,  8'hF7, 4, 1'b1, 8'h08, 8'h00, 8'h00);

    bus.in_raw = 8'hFF;
    bus.delay  = CW'(4);
    bus.enable = 1'b1;
    reset_n    = 1'b0;
    #1;
    check_outs("reset_async", 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    check_outs("reset_held", 8'h00, 8'h00, 8'h00);
    #2 reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].raw, int'(vecs[i].dly), vecs[i].en,
           vecs[i].lvl, vecs[i].prs, vecs[i].rls);
    end

    // 6b) ch3 release counting, frozen at count 2, then reset mid-hold
    repeat (4) step("rel_count", 8'hFF, 4, 1'b1, 8'h08, 8'h00, 8'h00);
    repeat (3) step("rel_hold",  8'hFF, 4, 1'b0, 8'h08, 8'h00, 8'h00);
    #3 reset_n = 1'b0;
    #1;
    check_outs("midhold_reset", 8'h00, 8'h00, 8'h00);
    @(posedge clock);
    #1;
    check_outs("midhold_reset_edge", 8'h00, 8'h00, 8'h00);
    #3 reset_n = 1'b1;
    #1;
    repeat (8) step("post_reset", 8'hFF, 4, 1'b1, 8'h00, 8'h00, 8'h00);

    // Fresh press after reset still works with the normal latency.
    repeat (5) step("post_reset_press", 8'hEF, 4, 1'b1, 8'h00, 8'h00, 8'h00);
    step("post_reset_press", 8'hEF, 4, 1'b1, 8'h10, 8'h10, 8'h00);
    step("post_reset_press", 8'hEF, 4, 1'b1, 8'h10, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
